// File: rtl/edf_ic_pkg.sv
// Shared definitions for the EDF interrupt arbiter: register map, CFG field
// positions, scanner states and the deadline ordering function.
package edf_ic_pkg;

    localparam logic [31:0] CTRL_OFFSET = 32'h0000_0000;
    localparam logic [31:0] TIME_OFFSET = 32'h0000_0004;
    localparam logic [31:0] CFG_BASE    = 32'h0000_0100;
    localparam int          CFG_STRIDE  = 4;

    localparam int CTRL_EN_BIT = 0;
    localparam int CFG_EN_BIT  = 31;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SCAN    = 2'd1,
        PUBLISH = 2'd2
    } scan_state_e;

    // Smaller signed slack is earlier; equal slack resolves to the lower id.
    function automatic logic earlier(
        input logic signed [31:0] slack_a,
        input logic        [31:0] id_a,
        input logic signed [31:0] slack_b,
        input logic        [31:0] id_b
    );
        logic result;
        if (slack_a < slack_b) begin
            result = 1'b1;
        end else if (slack_a == slack_b) begin
            result = (id_a < id_b);
        end else begin
            result = 1'b0;
        end
        return result;
    endfunction

endpackage

// File: rtl/edf_deadline_scanner.sv
// Time-multiplexed earliest-deadline scanner: walks ScanWidth entries per cycle,
// keeps a running best and publishes it as the presented winner.
module edf_deadline_scanner
    import edf_ic_pkg::*;
#(
    parameter int  NrIrqs    = 8,
    parameter int  TsWidth   = 16,
    parameter int  ScanWidth = 2,
    localparam int IdWidth   = $clog2(NrIrqs)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NrIrqs-1:0]               pending,
    input  logic [NrIrqs-1:0]               pending_live,
    input  logic [NrIrqs-1:0][TsWidth-1:0]  abs_deadline,
    input  logic [TsWidth-1:0]              now,
    input  logic                            kill,
    output logic                            irq_valid,
    output logic [IdWidth-1:0]              irq_id,
    output logic [TsWidth-1:0]              irq_deadline
);

    localparam int NrChunks   = NrIrqs / ScanWidth;
    localparam int ChunkWidth = (NrChunks > 1) ? $clog2(NrChunks) : 1;
    localparam logic [ChunkWidth-1:0] LastChunk = ChunkWidth'(NrChunks - 1);
    localparam logic [ChunkWidth-1:0] ChunkOne  = {{(ChunkWidth-1){1'b0}}, 1'b1};
    localparam logic [ChunkWidth-1:0] ChunkZero = {ChunkWidth{1'b0}};

    scan_state_e               state_r, state_s;
    logic [ChunkWidth-1:0]     chunk_r, chunk_s;
    logic                      best_found_r, best_found_s;
    logic [IdWidth-1:0]        best_id_r, best_id_s;
    logic [TsWidth-1:0]        best_abs_r, best_abs_s;
    logic                      valid_r, valid_s;
    logic [IdWidth-1:0]        id_r, id_s;
    logic [TsWidth-1:0]        deadline_r, deadline_s;

    logic                      cand_found_s;
    logic [IdWidth-1:0]        cand_id_s;
    logic [TsWidth-1:0]        cand_abs_s;
    logic [IdWidth-1:0]        idx_s;

    function automatic logic signed [31:0] sext(input logic [TsWidth-1:0] v);
        return 32'(signed'(v));
    endfunction

    // Chunk comparison, FSM next state and publish/abort of the winner registers.
    always_comb begin
        state_s      = state_r;
        chunk_s      = chunk_r;
        best_found_s = best_found_r;
        best_id_s    = best_id_r;
        best_abs_s   = best_abs_r;
        valid_s      = valid_r;
        id_s         = id_r;
        deadline_s   = deadline_r;
        cand_found_s = best_found_r;
        cand_id_s    = best_id_r;
        cand_abs_s   = best_abs_r;
        idx_s        = {IdWidth{1'b0}};

        // Slack is recomputed against the current time so entries seen in earlier chunks stay comparable.
        for (int j = 0; j < ScanWidth; j++) begin
            idx_s = IdWidth'(int'(chunk_r) * ScanWidth + j);
            if (pending[idx_s] &&
                (!cand_found_s ||
                 earlier(sext(abs_deadline[idx_s] - now), 32'(idx_s),
                         sext(cand_abs_s - now), 32'(cand_id_s)))) begin
                cand_found_s = 1'b1;
                cand_id_s    = idx_s;
                cand_abs_s   = abs_deadline[idx_s];
            end else begin
                cand_found_s = cand_found_s;
            end
        end

        case (state_r)
            IDLE: begin
                if (pending != {NrIrqs{1'b0}}) begin
                    state_s      = SCAN;
                    chunk_s      = ChunkZero;
                    best_found_s = 1'b0;
                end else begin
                    state_s = IDLE;
                end
            end
            SCAN: begin
                best_found_s = cand_found_s;
                best_id_s    = cand_id_s;
                best_abs_s   = cand_abs_s;
                if (chunk_r == LastChunk) begin
                    state_s = PUBLISH;
                end else begin
                    chunk_s = chunk_r + ChunkOne;
                end
            end
            PUBLISH: begin
                if (best_found_r && pending_live[best_id_r]) begin
                    valid_s    = 1'b1;
                    id_s       = best_id_r;
                    deadline_s = best_abs_r;
                end else begin
                    valid_s    = 1'b0;
                    id_s       = {IdWidth{1'b0}};
                    deadline_s = {TsWidth{1'b0}};
                end
                best_found_s = 1'b0;
                chunk_s      = ChunkZero;
                if (pending != {NrIrqs{1'b0}}) begin
                    state_s = SCAN;
                end else begin
                    state_s = IDLE;
                end
            end
            default: begin
                state_s      = IDLE;
                chunk_s      = ChunkZero;
                best_found_s = 1'b0;
            end
        endcase

        if (kill) begin
            valid_s      = 1'b0;
            id_s         = {IdWidth{1'b0}};
            deadline_s   = {TsWidth{1'b0}};
            state_s      = SCAN;
            chunk_s      = ChunkZero;
            best_found_s = 1'b0;
        end else begin
            state_s = state_s;
        end
    end

    // Scanner state, running best and presented-winner registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            chunk_r      <= ChunkZero;
            best_found_r <= 1'b0;
            best_id_r    <= {IdWidth{1'b0}};
            best_abs_r   <= {TsWidth{1'b0}};
            valid_r      <= 1'b0;
            id_r         <= {IdWidth{1'b0}};
            deadline_r   <= {TsWidth{1'b0}};
        end else begin
            state_r      <= state_s;
            chunk_r      <= chunk_s;
            best_found_r <= best_found_s;
            best_id_r    <= best_id_s;
            best_abs_r   <= best_abs_s;
            valid_r      <= valid_s;
            id_r         <= id_s;
            deadline_r   <= deadline_s;
        end
    end

    assign irq_valid    = valid_r;
    assign irq_id       = id_r;
    assign irq_deadline = deadline_r;

endmodule

// File: rtl/edf_irq_arbiter.sv
// EDF interrupt arbiter top: cfg registers, free-running timestamp, edge capture
// and per-line absolute deadlines feeding the deadline scanner.
module edf_irq_arbiter
    import edf_ic_pkg::*;
#(
    parameter int  NrIrqs    = 8,
    parameter int  TsWidth   = 16,
    parameter int  ScanWidth = 2,
    localparam int IdWidth   = $clog2(NrIrqs)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                cfg_req_i,
    input  logic                cfg_we_i,
    input  logic [31:0]         cfg_addr_i,
    input  logic [31:0]         cfg_wdata_i,
    output logic                cfg_rvalid_o,
    output logic [31:0]         cfg_rdata_o,
    input  logic [NrIrqs-1:0]   irq_i,
    output logic                irq_valid_o,
    output logic [IdWidth-1:0]  irq_id_o,
    output logic [TsWidth-1:0]  irq_deadline_o,
    input  logic                irq_ack_i
);

    localparam logic [TsWidth-1:0] TsOne = {{(TsWidth-1){1'b0}}, 1'b1};

    logic                            ctrl_en_r;
    logic [TsWidth-1:0]              time_r;
    logic [NrIrqs-1:0][TsWidth-1:0]  rel_r;
    logic [NrIrqs-1:0][TsWidth-1:0]  abs_r;
    logic [NrIrqs-1:0]               enable_r;
    logic [NrIrqs-1:0]               irq_prev_r;
    logic [NrIrqs-1:0]               pending_r;
    logic                            cfg_rvalid_r;
    logic [31:0]                     cfg_rdata_r;

    logic                            wr_ctrl_s;
    logic                            wr_time_s;
    logic [NrIrqs-1:0]               wr_cfg_s;
    logic [31:0]                     rd_data_s;
    logic [31:0]                     cfg_word_s;
    logic                            ack_fire_s;
    logic                            kill_s;
    logic [NrIrqs-1:0]               rise_s;
    logic [NrIrqs-1:0]               set_s;
    logic [NrIrqs-1:0]               pending_next_s;
    logic                            unused_wdata;

    assign unused_wdata = ^cfg_wdata_i;

    // Address decode and read-data mux for the cfg bus.
    always_comb begin
        wr_ctrl_s  = 1'b0;
        wr_time_s  = 1'b0;
        wr_cfg_s   = {NrIrqs{1'b0}};
        rd_data_s  = 32'h0000_0000;
        cfg_word_s = 32'h0000_0000;
        if (cfg_req_i) begin
            if (cfg_addr_i == CTRL_OFFSET) begin
                wr_ctrl_s              = cfg_we_i;
                rd_data_s[CTRL_EN_BIT] = ctrl_en_r;
            end else if (cfg_addr_i == TIME_OFFSET) begin
                wr_time_s = cfg_we_i;
                rd_data_s = 32'(time_r);
            end else begin
                for (int i = 0; i < NrIrqs; i++) begin
                    if (cfg_addr_i == CFG_BASE + 32'(CFG_STRIDE * i)) begin
                        wr_cfg_s[i]            = cfg_we_i;
                        cfg_word_s             = 32'(rel_r[i]);
                        cfg_word_s[CFG_EN_BIT] = enable_r[i];
                        rd_data_s              = cfg_word_s;
                    end else begin
                        wr_cfg_s[i] = 1'b0;
                    end
                end
            end
        end else begin
            rd_data_s = 32'h0000_0000;
        end
    end

    // Next pending state: an ack clears, a fresh edge re-arms, disabling overrides both.
    always_comb begin
        ack_fire_s     = irq_ack_i & irq_valid_o;
        rise_s         = irq_i & ~irq_prev_r;
        set_s          = {NrIrqs{1'b0}};
        pending_next_s = pending_r;
        for (int i = 0; i < NrIrqs; i++) begin
            if (ack_fire_s && (irq_id_o == IdWidth'(i))) begin
                pending_next_s[i] = 1'b0;
            end else begin
                pending_next_s[i] = pending_r[i];
            end
            if (rise_s[i] && enable_r[i] && !pending_next_s[i]) begin
                set_s[i]          = 1'b1;
                pending_next_s[i] = 1'b1;
            end else begin
                set_s[i] = 1'b0;
            end
            if (wr_cfg_s[i] && !cfg_wdata_i[CFG_EN_BIT]) begin
                set_s[i]          = 1'b0;
                pending_next_s[i] = 1'b0;
            end else begin
                set_s[i] = set_s[i];
            end
        end
        kill_s = ack_fire_s | (irq_valid_o & ~pending_next_s[irq_id_o]);
    end

    // Cfg registers, timestamp, edge history, pending flags and absolute deadlines.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ctrl_en_r    <= 1'b0;
            time_r       <= {TsWidth{1'b0}};
            rel_r        <= {(NrIrqs*TsWidth){1'b0}};
            abs_r        <= {(NrIrqs*TsWidth){1'b0}};
            enable_r     <= {NrIrqs{1'b0}};
            irq_prev_r   <= {NrIrqs{1'b0}};
            pending_r    <= {NrIrqs{1'b0}};
            cfg_rvalid_r <= 1'b0;
            cfg_rdata_r  <= 32'h0000_0000;
        end else begin
            if (wr_ctrl_s) begin
                ctrl_en_r <= cfg_wdata_i[CTRL_EN_BIT];
            end
            if (wr_time_s) begin
                time_r <= cfg_wdata_i[TsWidth-1:0];
            end else if (ctrl_en_r) begin
                time_r <= time_r + TsOne;
            end
            for (int i = 0; i < NrIrqs; i++) begin
                if (wr_cfg_s[i]) begin
                    rel_r[i]    <= cfg_wdata_i[TsWidth-1:0];
                    enable_r[i] <= cfg_wdata_i[CFG_EN_BIT];
                end
                if (set_s[i]) begin
                    abs_r[i] <= time_r + rel_r[i];
                end
            end
            irq_prev_r   <= irq_i;
            pending_r    <= pending_next_s;
            cfg_rvalid_r <= cfg_req_i & ~cfg_we_i;
            cfg_rdata_r  <= (cfg_req_i & ~cfg_we_i) ? rd_data_s : 32'h0000_0000;
        end
    end

    assign cfg_rvalid_o = cfg_rvalid_r;
    assign cfg_rdata_o  = cfg_rdata_r;

    edf_deadline_scanner #(
        .NrIrqs    (NrIrqs),
        .TsWidth   (TsWidth),
        .ScanWidth (ScanWidth)
    ) u_scanner (
        .clk          (clk_i),
        .rst          (rst_i),
        .pending      (pending_r),
        .pending_live (pending_next_s),
        .abs_deadline (abs_r),
        .now          (time_r),
        .kill         (kill_s),
        .irq_valid    (irq_valid_o),
        .irq_id       (irq_id_o),
        .irq_deadline (irq_deadline_o)
    );

endmodule
